// File: rtl/gpr_wb_arb_pkg.sv
// gpr_wb_arb_pkg
//   Shared constants and types for the GPR write-back path.
//   - Register file geometry (GPR_NUM, ADDR_W, DATA_W).
//   - Write-back source indices used to index grant vectors.
//   - Active-low enable levels and the reset-asserted level.
//   - wb_cmd_t: address/data pair carried by a write-back source.
package gpr_wb_arb_pkg;

  localparam int GPR_NUM = 32;
  localparam int ADDR_W  = $clog2(GPR_NUM);
  localparam int DATA_W  = 32;

  localparam int NUM_SRC = 3;
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_DBG = 2;

  // Register-file enables in this codebase are active-low.
  localparam logic ENABLE_    = 1'b0;
  localparam logic DISABLE_   = 1'b1;
  localparam logic RST_ENABLE = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_cmd_t;

endpackage

// File: rtl/gpr_wb_arb_scoreboard.sv
// gpr_scoreboard
//   One busy flop per general-purpose register, marking an in-flight write.
//   Ports:
//     clk, rst          clock, synchronous active-high reset (clears all bits)
//     i_set_valid/addr  reservation from decode: sets busy[addr]
//     i_clr_valid/addr  granted write-back: clears busy[addr]
//     o_busy            per-register busy vector
//     o_conflict        combinational: reservation targets an already-busy reg
//   A set and clear of the same register in one cycle leaves it busy.
module gpr_scoreboard
  import gpr_wb_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_set_valid,
  input  logic [ADDR_W-1:0]  i_set_addr,
  input  logic               i_clr_valid,
  input  logic [ADDR_W-1:0]  i_clr_addr,
  output logic [GPR_NUM-1:0] o_busy,
  output logic               o_conflict
);

  logic [GPR_NUM-1:0] r_busy;

  for (genvar gi = 0; gi < GPR_NUM; gi++) begin : g_busy
    logic w_set;
    logic w_clr;

    assign w_set = i_set_valid && (i_set_addr == ADDR_W'(gi));
    assign w_clr = i_clr_valid && (i_clr_addr == ADDR_W'(gi));

    // Set is checked first so a same-cycle reservation keeps the bit high.
    always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
        r_busy[gi] <= 1'b0;
      end else if (w_set) begin
        r_busy[gi] <= 1'b1;
      end else if (w_clr) begin
        r_busy[gi] <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_conflict = (rst != RST_ENABLE) && i_set_valid && r_busy[i_set_addr];

endmodule

// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb
//   Write-back arbiter for the GPR file's single write port, plus the
//   register scoreboard used by decode for RAW hazard stalls.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     {alu,mem,dbg}_valid      source has a write pending (held until granted)
//     {alu,mem,dbg}_ready      combinational grant, at most one high
//     {alu,mem,dbg}_addr/data  destination register and write data
//     rsv_valid, rsv_addr      decode reserves a destination register
//     rsv_conflict             reservation hit an already-busy register
//     busy                     per-register pending-write flags
//     we_, wr_addr, wr_data    registered register-file write command (we_ active-low)
//   dbg has absolute priority; alu and mem alternate through a one-bit
//   last-grant pointer that only moves on alu/mem grants.
module gpr_wb_arb
  import gpr_wb_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [ADDR_W-1:0]  alu_addr,
  input  logic [DATA_W-1:0]  alu_data,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic               dbg_valid,
  output logic               dbg_ready,
  input  logic [ADDR_W-1:0]  dbg_addr,
  input  logic [DATA_W-1:0]  dbg_data,
  input  logic               rsv_valid,
  input  logic [ADDR_W-1:0]  rsv_addr,
  output logic               rsv_conflict,
  output logic [GPR_NUM-1:0] busy,
  output logic               we_,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data
);

  wb_cmd_t            w_src_cmd [NUM_SRC];
  logic [NUM_SRC-1:0] w_gnt;
  logic               w_any_gnt;
  wb_cmd_t            w_cmd;

  // 1 = last alu/mem grant went to mem, so alu is favoured next.
  logic    r_last_mem;
  logic    r_we_;
  wb_cmd_t r_cmd;

  assign w_src_cmd[SRC_ALU] = '{addr: alu_addr, data: alu_data};
  assign w_src_cmd[SRC_MEM] = '{addr: mem_addr, data: mem_data};
  assign w_src_cmd[SRC_DBG] = '{addr: dbg_addr, data: dbg_data};

  always_comb begin
    w_gnt = '0;
    if (rst != RST_ENABLE) begin
      if (dbg_valid) begin
        w_gnt[SRC_DBG] = 1'b1;
      end else if (alu_valid && (!mem_valid || r_last_mem)) begin
        w_gnt[SRC_ALU] = 1'b1;
      end else if (mem_valid) begin
        w_gnt[SRC_MEM] = 1'b1;
      end
    end
  end

  assign w_any_gnt = |w_gnt;

  // Grant is one-hot, so an OR of masked commands is a clean mux.
  always_comb begin
    w_cmd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_gnt[i]) begin
        w_cmd = w_cmd | w_src_cmd[i];
      end
    end
  end

  assign alu_ready = w_gnt[SRC_ALU];
  assign mem_ready = w_gnt[SRC_MEM];
  assign dbg_ready = w_gnt[SRC_DBG];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_last_mem <= 1'b1;
    end else if (w_gnt[SRC_ALU]) begin
      r_last_mem <= 1'b0;
    end else if (w_gnt[SRC_MEM]) begin
      r_last_mem <= 1'b1;
    end
  end

  // Address/data hold their last value when idle; only we_ returns high.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_we_ <= DISABLE_;
      r_cmd <= '0;
    end else if (w_any_gnt) begin
      r_we_ <= ENABLE_;
      r_cmd <= w_cmd;
    end else begin
      r_we_ <= DISABLE_;
    end
  end

  assign we_     = r_we_;
  assign wr_addr = r_cmd.addr;
  assign wr_data = r_cmd.data;

  gpr_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_set_valid (rsv_valid),
    .i_set_addr  (rsv_addr),
    .i_clr_valid (w_any_gnt),
    .i_clr_addr  (w_cmd.addr),
    .o_busy      (busy),
    .o_conflict  (rsv_conflict)
  );

endmodule

// File: tb/tb_gpr_wb_arb.sv
// tb_gpr_wb_arb
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the arbiter, output register and scoreboard.
module tb_gpr_wb_arb;

  logic        clk;
  logic        rst;
  logic        sv [3];
  logic [4:0]  sa [3];
  logic [31:0] sd [3];
  logic        alu_ready, mem_ready, dbg_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_conflict;
  logic [31:0] busy;
  logic        we_;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  gpr_wb_arb dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (sv[0]),
    .alu_ready    (alu_ready),
    .alu_addr     (sa[0]),
    .alu_data     (sd[0]),
    .mem_valid    (sv[1]),
    .mem_ready    (mem_ready),
    .mem_addr     (sa[1]),
    .mem_data     (sd[1]),
    .dbg_valid    (sv[2]),
    .dbg_ready    (dbg_ready),
    .dbg_addr     (sa[2]),
    .dbg_data     (sd[2]),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .rsv_conflict (rsv_conflict),
    .busy         (busy),
    .we_          (we_),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model state
  int          last_rr;   // 0 = alu granted last, 1 = mem granted last
  logic [31:0] busy_m;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  int          g_last;    // source granted in the most recent step, -1 none

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    last_rr  = 1;
    busy_m   = '0;
    exp_we   = 1'b1;
    exp_addr = '0;
    exp_data = '0;
  endtask

  // Called at a negedge with inputs already driven. Checks combinational
  // outputs, advances the model across the next posedge, then checks the
  // registered outputs at the following negedge.
  task automatic step();
    int g;
    #1;
    g = -1;
    if (!rst) begin
      if (sv[2]) g = 2;
      else if (sv[0] && sv[1]) g = (last_rr == 1) ? 0 : 1;
      else if (sv[0]) g = 0;
      else if (sv[1]) g = 1;
    end
    chk("alu_ready", alu_ready, g == 0);
    chk("mem_ready", mem_ready, g == 1);
    chk("dbg_ready", dbg_ready, g == 2);
    chk("rsv_conflict", rsv_conflict, !rst && rsv_valid && busy_m[rsv_addr]);
    $display("cyc %0d rst=%0b v=%0b%0b%0b gnt=%0d rsv=%0b/%0d we_=%0b wa=%0d wd=%h",
             cyc, rst, sv[2], sv[1], sv[0], g, rsv_valid, rsv_addr, we_, wr_addr, wr_data);
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        busy_m[sa[g]] = 1'b0;
        exp_we   = 1'b0;
        exp_addr = sa[g];
        exp_data = sd[g];
        if (g < 2) last_rr = g;
      end else begin
        exp_we = 1'b1;
      end
      if (rsv_valid) busy_m[rsv_addr] = 1'b1;
    end
    g_last = g;
    @(negedge clk);
    cyc++;
    chk("we_", we_, exp_we);
    chk("wr_addr", wr_addr, exp_addr);
    chk("wr_data", wr_data, exp_data);
    chk("busy", busy, busy_m);
  endtask

  task automatic set_src(input int s, input logic v, input logic [4:0] a, input logic [31:0] d);
    sv[s] = v;
    sa[s] = a;
    sd[s] = d;
  endtask

  task automatic idle_srcs();
    for (int s = 0; s < 3; s++) set_src(s, 1'b0, 5'd0, 32'd0);
    rsv_valid = 1'b0;
    rsv_addr  = '0;
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) set_src(s, 1'b1, 5'(s + 1), 32'hC0DE_0000 + 32'(s));
    rsv_valid = 1'b1;
    rsv_addr  = 5'd6;
    model_reset();
    g_last = -1;
    @(negedge clk);

    // Reset held with every valid high
    step();
    step();

    // Release: alu and mem continuously valid, alu first then alternating
    rst = 1'b0;
    idle_srcs();
    set_src(0, 1'b1, 5'd3, 32'hA);
    set_src(1, 1'b1, 5'd4, 32'hB);
    for (int i = 0; i < 4; i++) step();

    // dbg beats both; round-robin resumes from the unchanged pointer
    set_src(2, 1'b1, 5'd7, 32'h55);
    step();
    sv[2] = 1'b0;
    step();
    step();

    // Scoreboard set, clear by write, and set-wins on same-cycle collision
    idle_srcs();
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    step();
    rsv_valid = 1'b0;
    set_src(0, 1'b1, 5'd5, 32'h1234);
    step();
    idle_srcs();
    step();
    set_src(0, 1'b1, 5'd5, 32'h5678);
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    step();
    idle_srcs();
    step();

    // Double reservation: conflict on the second only
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    step();
    step();
    rsv_valid = 1'b0;
    step();

    // Mid-stream reset swallows a mem grant
    set_src(1, 1'b1, 5'd2, 32'hDEAD);
    rsv_valid = 1'b1; rsv_addr = 5'd11;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_srcs();
    step();

    // Randomized traffic; a non-granted source holds its request
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < 3; s++) begin
        if (!sv[s] || g_last == s) begin
          set_src(s, ($urandom_range(0, 99) < ((s == 2) ? 15 : 60)),
                  5'($urandom_range(0, 7)), $urandom());
        end
      end
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_addr  = 5'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arb.md
# gpr_wb_arb

Write-back arbiter and register scoreboard for the general-purpose register file. Three write-back sources share the register file's single write port: ALU, load unit and debug unit. The block grants one source per cycle and drives a registered write command with an active-low enable. It also tracks which registers have an in-flight write so decode can stall on RAW hazards.

## Interface
- GPR_NUM, 32, number of registers
- ADDR_W, 5, register address width (clog2 GPR_NUM)
- DATA_W, 32, register data width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid / mem_valid / dbg_valid  in  1 each  source has a write pending
- alu_ready / mem_ready / dbg_ready  out  1 each  grant; transfer when valid&&ready
- alu_addr / mem_addr / dbg_addr  in  ADDR_W each  destination register
- alu_data / mem_data / dbg_data  in  DATA_W each  write data
- rsv_valid  in  1  decode reserves a destination register
- rsv_addr  in  ADDR_W  register being reserved
- rsv_conflict  out  1  pulse: reservation hit an already-busy register
- busy  out  GPR_NUM  per-register pending-write flags
- we_  out  1  register-file write enable, active-low, registered
- wr_addr  out  ADDR_W  register-file write address, registered
- wr_data  out  DATA_W  register-file write data, registered

## Operation
- Grant logic is combinational in cycle N. At most one ready is high, and only toward a valid source.
- Priority: dbg beats everything. alu and mem use round-robin via a 1-bit last-grant pointer.
  - Pointer reset state favours alu.
  - Pointer updates only on an alu or mem grant; a dbg grant leaves it unchanged.
- A granted source's addr/data are captured into the output registers at the end of cycle N.
- Output in cycle N+1: we_=0 with the captured wr_addr/wr_data. With no grant in N, cycle N+1 has we_=1 and wr_addr/wr_data hold their previous values.
- A source that is not granted must hold valid, addr and data stable until granted.
- Scoreboard is one flop per register.
  - rsv_valid sets busy[rsv_addr] at the clock edge.
  - A granted write, from any source including dbg, clears busy[addr] at the same edge that captures the write.
  - Set and clear of the same address in the same cycle: set wins and busy stays 1.
  - rsv_valid to a register whose busy is already 1: busy stays 1 and rsv_conflict=1 for that cycle (combinational).
- Register 0 gets no special treatment.

## Timing
- Reset values: we_=1, wr_addr=0, wr_data=0, busy=0, last-grant pointer=mem (so alu wins first). ready and rsv_conflict are combinational and are 0 while rst=1.
- Reset is synchronous. Asserting rst mid-stream:
  - drops the pending output write, so we_=1 the next cycle;
  - clears every busy bit;
  - ignores any same-cycle grant or reservation.
- Latency: granted in N, register file written at the end of N+1.
- busy[a] reads 0 in N+1, the same cycle we_ is low. A reader in N+1 gets the new value through the register file's write-through bypass.
- Throughput: one write per cycle, sustained.
- Starvation bound: with dbg idle, a continuously valid alu or mem is granted within 2 cycles.
- Continuous dbg traffic may starve alu and mem. This is intended; debug halts the core.

## Structure
- Shared package/header: source index constants (SRC_ALU=0, SRC_MEM=1, SRC_DBG=2) and the existing ENABLE_/DISABLE_ and RST_ENABLE constants.
- ADDR_W/DATA_W are taken from the shared GPR address/data bus widths.
- One natural sub-module: gpr_scoreboard. It holds the busy vector with set/clear ports, set-wins precedence and conflict detection.
- Arbitration and the output register stay in the top module.

## Test plan
- Reset: hold rst 2 cycles with all valids high. Required: every ready=0, we_=1, busy=0. Release rst with alu_valid=mem_valid=1: alu granted first.
- Round-robin: alu and mem both continuously valid (alu addr 3 data 0xA, mem addr 4 data 0xB). Required: grants alternate alu, mem, alu; we_=0 every cycle from the second cycle on; wr_addr alternates 3, 4.
- dbg priority: dbg_valid=1 (addr 7 data 0x55) together with alu and mem. Required: dbg_ready=1 only. Next cycle we_=0, wr_addr=7, wr_data=0x55. Round-robin resumes from the unchanged pointer.
- Scoreboard: rsv_valid addr 5 → busy[5]=1 next cycle. alu write to addr 5 granted in N → busy[5]=0 and we_=0 in N+1. Also, rsv of addr 5 in the same cycle as the grant → busy[5] stays 1.
- Conflict: reserve addr 9 twice with no write between. Required: rsv_conflict=1 on the second reservation only; busy[9]=1 throughout.
- Mid-operation reset: grant mem (addr 2) in cycle N, assert rst in N. Required: we_=1 in N+1, busy all 0, no register-file write.
